// File: rtl/uart_out_arbiter_if.sv
// uart_out_arbiter_if: request/response bundle between the character producers,
// the bench-side output strobe and the arbiter.
//   req_valid/req_ch/req_ready : per-requester push handshake (req_ch packed [N_REQ][8])
//   out_stall                  : hold off output pops
//   uart_out_valid/ch/src      : one-cycle char strobe with its source index
//   lock_busy/timeout_pulse    : arbiter status
// slave modport = arbiter side, master modport = producers/bench side.
interface uart_out_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0][7:0] req_ch;
  logic [N_REQ-1:0]      req_ready;
  logic                  out_stall;
  logic                  uart_out_valid;
  logic [7:0]            uart_out_ch;
  logic [ID_W-1:0]       uart_out_src;
  logic                  lock_busy;
  logic                  timeout_pulse;

  modport slave (
    input  req_valid, req_ch, out_stall,
    output req_ready, uart_out_valid, uart_out_ch, uart_out_src, lock_busy, timeout_pulse
  );

  modport master (
    output req_valid, req_ch, out_stall,
    input  req_ready, uart_out_valid, uart_out_ch, uart_out_src, lock_busy, timeout_pulse
  );
endinterface

// File: rtl/uart_out_arbiter.sv
// uart_out_arbiter: shares the single simulation UART output channel among N_REQ
// character producers. Each producer is buffered in a private FIFO; the channel is
// granted round-robin and held for a whole line (until a popped 8'h0A), so lines from
// different sources never interleave. An owner that stays empty for LOCK_TIMEOUT
// consecutive unstalled cycles loses the lock (timeout_pulse).
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : uart_out_arbiter_if.slave (request handshake, output strobe, status)

// Per-requester FIFO lane. Count-based full/empty, no bypass: a char pushed at edge k
// is visible at the head only after that edge.
module uart_out_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       ready
);
  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push;

  // Full refuses a push even if a pop happens in the same cycle.
  assign ready   = (count != FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ready;
  assign head    = mem[rd_ptr];

  // Storage needs no reset; only the pointers/count define validity.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers are AW bits wide, so wrap modulo DEPTH is implicit (DEPTH is a power of two).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module uart_out_arbiter #(
  parameter int N_REQ        = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int LOCK_TIMEOUT = 256,
  parameter int ID_W         = $clog2(N_REQ)
) (
  input logic                 clock,
  input logic                 reset,
  uart_out_arbiter_if.slave   bus
);
  localparam int                TW      = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TW-1:0]     T_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [ID_W:0]     N_W     = (ID_W+1)'(N_REQ);
  localparam logic [ID_W-1:0]   LAST_ID = ID_W'(N_REQ - 1);
  localparam logic [7:0]        NL      = 8'h0A;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state;
  logic [ID_W-1:0]       owner, rr_ptr;
  logic [TW-1:0]         tcnt;

  logic [N_REQ-1:0]      empty, rdy, pop_vec;
  logic [N_REQ-1:0][7:0] head;
  logic [7:0]            owner_head;
  logic                  pop;

  logic [ID_W-1:0]       sel;
  logic                  sel_vld;
  logic [ID_W:0]         idx;

  logic                  out_valid, lock_q, tpulse;
  logic [7:0]            out_ch;
  logic [ID_W-1:0]       out_src;

  // Per-requester FIFO lanes.
  for (genvar i = 0; i < N_REQ; i++) begin : g_fifo
    uart_out_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (bus.req_valid[i]),
      .din   (bus.req_ch[i]),
      .pop   (pop_vec[i]),
      .head  (head[i]),
      .empty (empty[i]),
      .ready (rdy[i])
    );
  end

  // Round-robin pick: first non-empty lane scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  // idx carries one extra bit so the wrap works for non-power-of-two N_REQ.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    idx     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (idx >= N_W) idx = idx - N_W;
      if (!sel_vld && !empty[idx[ID_W-1:0]]) begin
        sel     = idx[ID_W-1:0];
        sel_vld = 1'b1;
      end
    end
  end

  assign owner_head = head[owner];
  assign pop        = (state == LOCKED) && !bus.out_stall && !empty[owner];

  always_comb begin
    pop_vec        = '0;
    pop_vec[owner] = pop;
  end

  // Arbiter FSM with registered outputs. The output strobe lags the pop edge by one
  // cycle; the lock ends on the edge that pops a newline or when the idle counter
  // has seen LOCK_TIMEOUT consecutive empty, unstalled owner cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      tcnt      <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_src   <= '0;
      lock_q    <= 1'b0;
      tpulse    <= 1'b0;
    end else begin
      out_valid <= pop;
      tpulse    <= 1'b0;
      if (pop) begin
        out_ch  <= owner_head;
        out_src <= owner;
      end
      unique case (state)
        IDLE: begin
          if (sel_vld) begin
            owner  <= sel;
            rr_ptr <= (sel == LAST_ID) ? '0 : sel + 1'b1;
            state  <= LOCKED;
            lock_q <= 1'b1;
            tcnt   <= '0;
          end
        end
        LOCKED: begin
          // Stall freezes everything, including the idle counter.
          if (!bus.out_stall) begin
            if (pop) begin
              tcnt <= '0;
              if (owner_head == NL) begin
                state  <= IDLE;
                lock_q <= 1'b0;
              end
            end else if (tcnt == T_LAST) begin
              state  <= IDLE;
              lock_q <= 1'b0;
              tpulse <= 1'b1;
              tcnt   <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready      = rdy;
  assign bus.uart_out_valid = out_valid;
  assign bus.uart_out_ch    = out_ch;
  assign bus.uart_out_src   = out_src;
  assign bus.lock_busy      = lock_q;
  assign bus.timeout_pulse  = tpulse;
endmodule

// File: tb/tb_uart_out_arbiter.sv
// Directed bench for uart_out_arbiter (N_REQ=4, FIFO_DEPTH=8, LOCK_TIMEOUT=16).
// Inputs are driven 1ns after the rising edge; outputs are checked at that point and
// the output strobe is also logged at the falling edge for sequence checks.
module tb_uart_out_arbiter;
  logic clock, reset;
  int   tests = 0;
  int   fails = 0;
  int   tpulses = 0;
  logic [9:0] outq [$];
  logic acc;

  uart_out_arbiter_if #(.N_REQ(4)) bus ();

  uart_out_arbiter #(.N_REQ(4), .FIFO_DEPTH(8), .LOCK_TIMEOUT(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Log every emitted char as {src, ch}, and count timeout pulses.
  always @(negedge clock) begin
    if (bus.uart_out_valid === 1'b1) outq.push_back({bus.uart_out_src, bus.uart_out_ch});
    if (bus.timeout_pulse === 1'b1) tpulses++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int idx, input logic [1:0] src, input logic [7:0] ch);
    logic [9:0] got;
    got = (idx < outq.size()) ? outq[idx] : 10'h3FF;
    chk($sformatf("%s[%0d]", tag, idx), {22'b0, got}, {22'b0, src, ch});
  endtask

  // Push char c on every requester in mask for one edge.
  task automatic drive(input logic [3:0] mask, input logic [7:0] c);
    bus.req_valid = mask;
    for (int r = 0; r < 4; r++) bus.req_ch[r] = c;
    step();
    bus.req_valid = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    outq.delete();
  endtask

  initial begin
    reset = 1'b0;
    bus.req_valid = '0;
    bus.req_ch    = '0;
    bus.out_stall = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_valid", bus.uart_out_valid, 1'b0);
    chk("rst_ch",    bus.uart_out_ch,    8'h00);
    chk("rst_src",   bus.uart_out_src,   2'd0);
    chk("rst_lock",  bus.lock_busy,      1'b0);
    chk("rst_tpl",   bus.timeout_pulse,  1'b0);
    reset = 1'b1;
    step();
    chk("rst_ready", bus.req_ready, 4'hF);

    // T1: "hi\n" on req0, cycle exact
    drive(4'b0001, 8'h68);
    chk("t1_v_k",    bus.uart_out_valid, 1'b0);
    chk("t1_lock_k", bus.lock_busy, 1'b0);
    drive(4'b0001, 8'h69);
    chk("t1_v_k1",    bus.uart_out_valid, 1'b0);
    chk("t1_lock_k1", bus.lock_busy, 1'b1);
    drive(4'b0001, 8'h0A);
    chk("t1_v0",  bus.uart_out_valid, 1'b1);
    chk("t1_c0",  bus.uart_out_ch, 8'h68);
    chk("t1_s0",  bus.uart_out_src, 2'd0);
    step();
    chk("t1_v1",  bus.uart_out_valid, 1'b1);
    chk("t1_c1",  bus.uart_out_ch, 8'h69);
    step();
    chk("t1_v2",  bus.uart_out_valid, 1'b1);
    chk("t1_c2",  bus.uart_out_ch, 8'h0A);
    chk("t1_unlock", bus.lock_busy, 1'b0);
    step();
    chk("t1_v3",  bus.uart_out_valid, 1'b0);
    chk("t1_n",   outq.size(), 3);

    // T2: req0 and req1 push "AB\n" together from rr_ptr=0
    pulse_reset();
    drive(4'b0011, 8'h41);
    drive(4'b0011, 8'h42);
    drive(4'b0011, 8'h0A);
    for (int i = 0; i < 14; i++) step();
    chk("t2_n", outq.size(), 6);
    chk_out("t2", 0, 2'd0, 8'h41);
    chk_out("t2", 1, 2'd0, 8'h42);
    chk_out("t2", 2, 2'd0, 8'h0A);
    chk_out("t2", 3, 2'd1, 8'h41);
    chk_out("t2", 4, 2'd1, 8'h42);
    chk_out("t2", 5, 2'd1, 8'h0A);

    // T3: all four push "x\nx\n"; grants rotate 0,1,2,3,0,1,2,3
    pulse_reset();
    drive(4'b1111, 8'h78);
    drive(4'b1111, 8'h0A);
    drive(4'b1111, 8'h78);
    drive(4'b1111, 8'h0A);
    for (int i = 0; i < 30; i++) step();
    chk("t3_n", outq.size(), 16);
    for (int i = 0; i < 16; i++)
      chk_out("t3", i, 2'((i / 2) % 4), (i % 2 == 1) ? 8'h0A : 8'h78);
    outq.delete();

    // T4: req0 locks on an open line; req2 fills its FIFO and is back-pressured
    drive(4'b0001, 8'h4C);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_rdy_pre%0d", i), bus.req_ready[2], 1'b1);
      drive(4'b0100, 8'(8'h30 + i));
    end
    chk("t4_full", bus.req_ready[2], 1'b0);
    bus.req_valid = 4'b0100;
    for (int r = 0; r < 4; r++) bus.req_ch[r] = 8'h0A;
    step();
    step();
    chk("t4_held", bus.req_ready[2], 1'b0);
    chk("t4_lock0", bus.lock_busy, 1'b1);
    bus.req_valid = 4'b0101;
    step();
    bus.req_valid = 4'b0100;
    acc = 1'b0;
    for (int i = 0; i < 30 && !acc; i++) begin
      if (bus.req_ready[2]) acc = 1'b1;
      step();
    end
    bus.req_valid = '0;
    chk("t4_accept", acc, 1'b1);
    for (int i = 0; i < 15; i++) step();
    chk("t4_n", outq.size(), 11);
    chk_out("t4", 0, 2'd0, 8'h4C);
    chk_out("t4", 1, 2'd0, 8'h0A);
    for (int i = 0; i < 8; i++) chk_out("t4", 2 + i, 2'd2, 8'(8'h30 + i));
    chk_out("t4", 10, 2'd2, 8'h0A);
    chk("t4_unlock", bus.lock_busy, 1'b0);
    chk("t4_no_to", tpulses, 0);
    outq.delete();

    // T5: req0 "ab" never terminated; timeout 16 cycles after last pop, then req1
    drive(4'b0001, 8'h61);
    drive(4'b0001, 8'h62);
    drive(4'b0010, 8'h5A);
    drive(4'b0010, 8'h0A);
    chk("t5_lastpop", bus.uart_out_ch, 8'h62);
    for (int i = 0; i < 15; i++) step();
    chk("t5_tpl_early", bus.timeout_pulse, 1'b0);
    chk("t5_lock_early", bus.lock_busy, 1'b1);
    step();
    chk("t5_tpl", bus.timeout_pulse, 1'b1);
    chk("t5_unlock", bus.lock_busy, 1'b0);
    step();
    chk("t5_tpl_one", bus.timeout_pulse, 1'b0);
    chk("t5_regrant", bus.lock_busy, 1'b1);
    for (int i = 0; i < 5; i++) step();
    chk("t5_n", outq.size(), 4);
    chk_out("t5", 0, 2'd0, 8'h61);
    chk_out("t5", 1, 2'd0, 8'h62);
    chk_out("t5", 2, 2'd1, 8'h5A);
    chk_out("t5", 3, 2'd1, 8'h0A);
    chk("t5_tcount", tpulses, 1);
    outq.delete();

    // T6: stall mid-line, then reset mid-line
    drive(4'b0010, 8'h70);
    drive(4'b0010, 8'h71);
    drive(4'b0010, 8'h72);
    drive(4'b0010, 8'h0A);
    chk("t6_q", bus.uart_out_ch, 8'h71);
    bus.out_stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        bus.req_valid = 4'b1000;
        bus.req_ch[3] = 8'h51;
      end
      step();
      bus.req_valid = '0;
      chk($sformatf("t6_stall_v%0d", i), bus.uart_out_valid, 1'b0);
      chk($sformatf("t6_stall_l%0d", i), bus.lock_busy, 1'b1);
    end
    chk("t6_stall_to", tpulses, 1);
    bus.out_stall = 1'b0;
    step();
    chk("t6_resume_v", bus.uart_out_valid, 1'b1);
    chk("t6_resume_c", bus.uart_out_ch, 8'h72);
    chk("t6_resume_s", bus.uart_out_src, 2'd1);
    chk("t6_pre_n", outq.size(), 2);
    reset = 1'b0;
    #1;
    chk("t6_rst_v", bus.uart_out_valid, 1'b0);
    chk("t6_rst_c", bus.uart_out_ch, 8'h00);
    chk("t6_rst_s", bus.uart_out_src, 2'd0);
    chk("t6_rst_l", bus.lock_busy, 1'b0);
    outq.delete();
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("t6_post_n", outq.size(), 0);
    chk("t6_post_l", bus.lock_busy, 1'b0);
    chk("t6_post_rdy", bus.req_ready, 4'hF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_out_arbiter.md
Name: uart_out_arbiter

Overview:
- Shares the single simulation UART output channel (uart_out_valid/uart_out_ch, printed by the bench one char per valid cycle) among N_REQ character producers, e.g. multiple harts or devices in SimTop.
- Buffers each requester in a private FIFO.
- Grants the channel round-robin with line-granular locking, so output lines from different sources never interleave.
- A timeout releases a lock held by a requester that stops mid-line.

Parameters:
N_REQ, 4, number of requesters (2..16)
FIFO_DEPTH, 8, entries per requester FIFO; power of two, >= 2
LOCK_TIMEOUT, 256, consecutive idle owner cycles before forced lock release (>= 1)
ID_W, $clog2(N_REQ), requester index width

Ports:
clock  in  1  sole clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
req_valid  in  N_REQ  per-requester char valid
req_ch  in  8*N_REQ  per-requester char; requester i uses bits [8i+7:8i]
req_ready  out  N_REQ  per-requester FIFO not full
out_stall  in  1  hold off output (e.g. bench in reset/init); no pops while 1
uart_out_valid  out  1  one-cycle char strobe to the bench
uart_out_ch  out  8  char, meaningful only when uart_out_valid=1
uart_out_src  out  ID_W  requester that produced the current char
lock_busy  out  1  1 while state=LOCKED
timeout_pulse  out  1  one-cycle pulse when a lock is force-released

Behaviour:
- Reset (reset=0, async):
  - All FIFOs empty; state=IDLE; owner=0; rr_ptr=0; timeout counter=0.
  - uart_out_valid=0, uart_out_ch=0, uart_out_src=0, lock_busy=0, timeout_pulse=0.
  - req_ready=all 1s once reset deasserts.
  - Reset mid-line discards all buffered chars; no partial output follows.
- FIFO i:
  - Push on req_valid[i] & req_ready[i].
  - req_ready[i] = !full[i], registered-count based; no bypass.
  - Push and pop in the same cycle on a non-full FIFO is legal; occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Full is count==FIFO_DEPTH; a full FIFO refuses a push even when a pop occurs the same cycle.
- State IDLE:
  - If any FIFO is non-empty, select the first non-empty index scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - On select: owner<=sel, rr_ptr<=(sel+1) mod N_REQ, state<=LOCKED, timeout counter<=0.
  - No pop occurs in IDLE.
- State LOCKED:
  - Pop condition: out_stall=0 and FIFO[owner] non-empty.
  - On pop, next cycle: uart_out_valid=1, uart_out_ch=head char, uart_out_src=owner. Output is registered, one cycle after the pop edge.
  - Popped char == 8'h0A: state<=IDLE (lock ends at newline).
  - No pop with out_stall=0 and FIFO[owner] empty: counter++.
    - When counter reaches LOCKUP_TIMEOUT-1, on that edge: state<=IDLE, timeout_pulse=1 for one cycle.
  - out_stall=1: no pop, counter frozen, uart_out_valid=0.
- uart_out_valid is 0 in every cycle not following a pop. At most one char per cycle.
- Latency:
  - Arbiter IDLE, empty system: push at edge k → grant at k+1 → pop at k+2 → uart_out_valid high after k+2.
  - Already-locked owner with empty FIFO: push at k, pop at k+1.
- Sustained throughput for a locked owner: 1 char/cycle.
- Chars of other requesters wait in their FIFOs; when full, they backpressure via req_ready=0. Nothing is dropped.

Test Plan:
- Req0 sends "hi\n" (0x68,0x69,0x0A) from reset release, out_stall=0 → uart_out_valid high 3 consecutive cycles starting 2 cycles after first push; src=0; then lock_busy=0.
- Req0 and req1 both push "AB\n" on the same cycle, rr_ptr=0 → output "AB\nAB\n"; src 0,0,0,1,1,1; no interleave.
- All 4 requesters continuously push single-char lines "x\n" → grants cycle 0,1,2,3,0; each requester gets 1 line per 4.
- Req2 pushes 8 chars while req0 holds a lock on an unterminated line → after 8 pushes req_ready[2]=0 and the 9th is held; no char is lost; all chars appear in order after req0's newline.
- Req0 sends "ab" with no newline, then idles → timeout_pulse asserts LOCK_TIMEOUT cycles after the last pop; req1's pending line is then granted.
- out_stall=1 for 10 cycles mid-line → uart_out_valid=0 and no timeout; output resumes next cycle after release. Then assert reset=0 mid-line → all outputs 0 immediately; FIFOs empty after release.
